sync_fifo_param: RTL and testbench

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/sync_fifo_ram.sv | 27 ++
 rtl/sync_fifo_param.sv | 114 +++++++++++
 tb/tb_sync_fifo_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared constants and the width helper for the synchronous FIFO.
// The FIFO top also honours SYNC_FIFO_FWFT_EN (first-word-fall-through read port).
package sync_fifo_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 8;

   // Ceiling log2; elaboration-time only, sizes pointers and the occupancy count.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// FIFO storage array: synchronous write port, asynchronous read port.
module sync_fifo_ram
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   localparam int AW = clog2(DEPTH)
)(
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with sticky overflow/underflow and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; default is a registered read port.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1,
   localparam int AW = clog2(DEPTH),
   localparam int CW = AW + 1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] data_in,
   input  logic             rd,
   input  logic             flush,
   input  logic             clr_err,
   output logic [WIDTH-1:0] data_out,
   output logic             empty,
   output logic             full,
   output logic             almost_empty,
   output logic             almost_full,
   output logic [CW-1:0]    fifo_cnt,
   output logic             overflow,
   output logic             underflow
);

   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             wr_acc;
   logic             rd_acc;
   logic             ram_we;
   logic [WIDTH-1:0] ram_rdata;
   logic             ovf_q;
   logic             udf_q;

   assign empty        = (cnt == '0);
   assign full         = (cnt == CW'(DEPTH));
   assign almost_full  = (int'(cnt) >= AF_LEVEL);
   assign almost_empty = (int'(cnt) <= AE_LEVEL);
   assign fifo_cnt     = cnt;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   // A read on a full FIFO frees the slot the concurrent write lands in.
   assign wr_acc = wr & (~full | rd);
   assign rd_acc = rd & ~empty;
   assign ram_we = wr_acc & ~flush & ~rst;

   sync_fifo_ram #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr),
      .wdata (data_in),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_acc, rd_acc})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // A new error event wins over a same-cycle clear so no event is lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         if (!flush && wr && !wr_acc) ovf_q <= 1'b1;
         else if (clr_err)            ovf_q <= 1'b0;
         if (!flush && rd && empty)   udf_q <= 1'b1;
         else if (clr_err)            udf_q <= 1'b0;
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign data_out = empty ? '0 : ram_rdata;
`else
   logic [WIDTH-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         dout_q <= '0;
      end else if (!flush && rd_acc) begin
         dout_q <= ram_rdata;
      end
   end

   assign data_out = dout_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (WIDTH=8, DEPTH=8, AF_LEVEL=7, AE_LEVEL=1).
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       rst, wr, rd, flush, clr_err;
   logic [7:0] data_in, data_out;
   logic       empty, full, almost_empty, almost_full;
   logic [3:0] fifo_cnt;
   logic       overflow, underflow;

   logic [7:0] sb[$];
   int         m_cnt;
   logic       m_ov, m_un;
   logic [7:0] m_dout, exp_rd, rd_val, pre_dout;
   logic       popped;
   int         checks = 0;
   int         errors = 0;

   sync_fifo_param #(
      .WIDTH(8), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)
   ) dut (
      .clk(clk), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
      .flush(flush), .clr_err(clr_err), .data_out(data_out),
      .empty(empty), .full(full), .almost_empty(almost_empty),
      .almost_full(almost_full), .fifo_cnt(fifo_cnt),
      .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_dout();
`ifdef SYNC_FIFO_FWFT_EN
      return (sb.size() > 0) ? sb[0] : 8'h00;
`else
      return m_dout;
`endif
   endfunction

   // One clock of stimulus; the reference model advances alongside and the popped word lands in exp_rd.
   task automatic drive_cycle(input logic w, input logic [7:0] d, input logic r,
                              input logic f, input logic c, input logic rs);
      logic w_acc, r_acc;
      wr = w; data_in = d; rd = r; flush = f; clr_err = c; rst = rs;
      popped = 1'b0;
      if (rs) begin
         sb.delete(); m_cnt = 0; m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00;
      end else if (f) begin
         sb.delete(); m_cnt = 0;
         if (c) begin m_ov = 1'b0; m_un = 1'b0; end
      end else begin
         w_acc = w && (m_cnt < 8 || r);
         r_acc = r && (m_cnt > 0);
         if (w && !w_acc) m_ov = 1'b1; else if (c) m_ov = 1'b0;
         if (r && m_cnt == 0) m_un = 1'b1; else if (c) m_un = 1'b0;
         if (r_acc) begin exp_rd = sb.pop_front(); m_dout = exp_rd; popped = 1'b1; m_cnt--; end
         if (w_acc) begin sb.push_back(d); m_cnt++; end
      end
      #3 pre_dout = data_out;
      @(posedge clk); #1;
`ifdef SYNC_FIFO_FWFT_EN
      rd_val = pre_dout;
`else
      rd_val = data_out;
`endif
      wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; rst = 1'b0; data_in = 8'h00;
   endtask

   task automatic do_write(input logic [7:0] d);
      drive_cycle(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_read();
      drive_cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=0", fifo_cnt); end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
      checks++; if (almost_empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_ae got=%b exp=1", almost_empty); end
      checks++; if (almost_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_af got=%b exp=0", almost_full); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_dout got=%h exp=00", data_out); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got=%b%b exp=00", overflow, underflow); end
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 8; i++) begin
         do_write(8'(i));
         checks++; if (fifo_cnt !== 4'(m_cnt)) begin errors++; $display("[TB] FAIL fill_cnt got=%0d exp=%0d", fifo_cnt, m_cnt); end
      end
      checks++; if (full !== 1'b1 || almost_full !== 1'b1) begin errors++; $display("[TB] FAIL fill_full got=%b%b exp=11", full, almost_full); end
      for (int i = 1; i <= 8; i++) begin
         do_read();
         checks++; if (rd_val !== exp_rd) begin errors++; $display("[TB] FAIL drain_data got=%h exp=%h", rd_val, exp_rd); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL drain_empty got=%b exp=1", empty); end
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL drain_err got=%b%b exp=00", overflow, underflow); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) do_write(8'(8'h10 + i));
      drive_cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got=%b exp=1", overflow); end
      checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("[TB] FAIL ovf_cnt got=%0d exp=8", fifo_cnt); end
      drive_cycle(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("[TB] FAIL ovf_wrrd_cnt got=%0d exp=8", fifo_cnt); end
      checks++; if (rd_val !== exp_rd) begin errors++; $display("[TB] FAIL ovf_wrrd_data got=%h exp=%h", rd_val, exp_rd); end
      for (int i = 0; i < 8; i++) begin
         do_read();
         checks++; if (rd_val !== exp_rd) begin errors++; $display("[TB] FAIL ovf_drain got=%h exp=%h", rd_val, exp_rd); end
      end
      checks++; if (rd_val !== 8'hAA) begin errors++; $display("[TB] FAIL ovf_last got=%h exp=aa", rd_val); end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_underflow();
      do_read();
      checks++; if (underflow !== 1'b1) begin errors++; $display("[TB] FAIL udf_flag got=%b exp=1", underflow); end
      checks++; if (data_out !== exp_dout()) begin errors++; $display("[TB] FAIL udf_dout got=%h exp=%h", data_out, exp_dout()); end
      drive_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++; if (fifo_cnt !== 4'd1) begin errors++; $display("[TB] FAIL udf_wrrd_cnt got=%0d exp=1", fifo_cnt); end
      checks++; if (underflow !== m_un) begin errors++; $display("[TB] FAIL udf_sticky got=%b exp=%b", underflow, m_un); end
      drive_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("[TB] FAIL udf_clear got=%b%b exp=00", overflow, underflow); end
      do_read();
      checks++; if (rd_val !== exp_rd) begin errors++; $display("[TB] FAIL udf_data got=%h exp=%h", rd_val, exp_rd); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 3; i++) do_write(8'(8'h20 + i));
      for (int i = 0; i < 20; i++) begin
         drive_cycle(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, 1'b0, 1'b0);
         checks++; if (fifo_cnt !== 4'd3) begin errors++; $display("[TB] FAIL wrap_cnt got=%0d exp=3", fifo_cnt); end
         checks++; if (rd_val !== exp_rd) begin errors++; $display("[TB] FAIL wrap_data got=%h exp=%h", rd_val, exp_rd); end
      end
      for (int i = 0; i < 3; i++) begin
         do_read();
         checks++; if (rd_val !== exp_rd) begin errors++; $display("[TB] FAIL wrap_drain got=%h exp=%h", rd_val, exp_rd); end
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) do_write(8'(8'h60 + i));
      drive_cycle(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++; if (fifo_cnt !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL flush_state got=%0d/%b exp=0/1", fifo_cnt, empty); end
      checks++; if (data_out !== exp_dout()) begin errors++; $display("[TB] FAIL flush_dout got=%h exp=%h", data_out, exp_dout()); end
      do_write(8'h11);
      do_read();
      checks++; if (rd_val !== exp_rd || exp_rd !== 8'h11) begin errors++; $display("[TB] FAIL flush_readback got=%h exp=11", rd_val); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) do_write(8'(8'h70 + i));
      drive_cycle(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b1);
      checks++; if (fifo_cnt !== 4'd0 || empty !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_state got=%0d/%b exp=0/1", fifo_cnt, empty); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_dout got=%h exp=00", data_out); end
      do_write(8'h33);
`ifdef SYNC_FIFO_FWFT_EN
      checks++; if (data_out !== 8'h33) begin errors++; $display("[TB] FAIL rstmid_fwft got=%h exp=33", data_out); end
`endif
      do_read();
      checks++; if (rd_val !== exp_rd) begin errors++; $display("[TB] FAIL rstmid_data got=%h exp=%h", rd_val, exp_rd); end
   endtask

   task automatic test_random();
      logic w, r, c;
      for (int i = 0; i < 120; i++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 9) == 0);
         drive_cycle(w, 8'($urandom_range(0, 255)), r, 1'b0, c, 1'b0);
         checks++; if (fifo_cnt !== 4'(m_cnt)) begin errors++; $display("[TB] FAIL rand_cnt got=%0d exp=%0d", fifo_cnt, m_cnt); end
         checks++; if (full !== (m_cnt == 8) || empty !== (m_cnt == 0)) begin errors++; $display("[TB] FAIL rand_fe got=%b%b cnt=%0d", full, empty, m_cnt); end
         checks++; if (almost_full !== (m_cnt >= 7) || almost_empty !== (m_cnt <= 1)) begin errors++; $display("[TB] FAIL rand_almost got=%b%b cnt=%0d", almost_full, almost_empty, m_cnt); end
         checks++; if (overflow !== m_ov || underflow !== m_un) begin errors++; $display("[TB] FAIL rand_err got=%b%b exp=%b%b", overflow, underflow, m_ov, m_un); end
         if (popped) begin
            checks++; if (rd_val !== exp_rd) begin errors++; $display("[TB] FAIL rand_data got=%h exp=%h", rd_val, exp_rd); end
         end
      end
   endtask

   initial begin
      rst = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = 8'h00;
      m_cnt = 0; m_ov = 1'b0; m_un = 1'b0; m_dout = 8'h00; exp_rd = 8'h00; popped = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_wrap();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
      $finish;
   end

endmodule
